// File: rtl/alu_multicycle_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle_if
// Description : Issue/result bundle between EX-stage control and the
//               multi-cycle ALU. The master drives the request side, the
//               slave (the ALU) drives the result side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [SHW-1:0]   shamt_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] hi_o;
    logic             zero_o;
    logic             overflow_o;
    logic             div_by_zero_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i, shamt_i,
        input  ready_o, done_o, result_o, hi_o, zero_o, overflow_o, div_by_zero_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
        output ready_o, done_o, result_o, hi_o, zero_o, overflow_o, div_by_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : alu_multicycle
// Description : EX-stage ALU with start/ready/done handshake. Single-cycle
//               ops finish one cycle after issue; MUL/DIV/DIVU iterate one
//               bit per cycle on a shared shift-add / restoring-divide engine.
//               Define ALU_MULDIV_EN to compile in the iterative engine;
//               without it MUL/DIV/DIVU return zero in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_multicycle_if.slave bus
);
    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1111;
    localparam logic [3:0] c_OP_SLL  = 4'b1000;
    localparam logic [3:0] c_OP_SLLV = 4'b1001;
    localparam logic [3:0] c_OP_SRL  = 4'b1100;
    localparam logic [3:0] c_OP_SRA  = 4'b1101;
    localparam logic [3:0] c_OP_LUI  = 4'b1010;
    localparam logic [3:0] c_OP_BNE  = 4'b1011;
    localparam logic [3:0] c_OP_NOP  = 4'b1110;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] c_OP_MUL  = 4'b0011;
    localparam logic [3:0] c_OP_DIV  = 4'b0100;
    localparam logic [3:0] c_OP_DIVU = 4'b0101;
    localparam logic [SHW-1:0] c_LAST    = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] c_CNT_ONE = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] w_sum, w_diff;
    logic [WIDTH-1:0] w_sc_res, w_sc_hi;
    logic             w_sc_zero, w_sc_ovf, w_sc_dbz;
    logic             w_ready;

`ifdef ALU_MULDIV_EN
    // Engine: {hi,lo} working register; hi = partial product / remainder,
    // lo = multiplier / dividend being consumed.
    logic [2*WIDTH-1:0] eng_q, eng_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH:0]     w_mul_sum, w_div_tmp;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
    logic [WIDTH-1:0]   w_quot, w_remd;
    logic               w_last;
`endif

    // Single-cycle result for the opcode currently on the bus
    always_comb begin
        w_sum    = bus.src1_i + bus.src2_i;
        w_diff   = bus.src1_i - bus.src2_i;
        w_sc_res = '0;
        w_sc_hi  = '0;
        w_sc_ovf = 1'b0;
        w_sc_dbz = 1'b0;
        case (bus.ctrl_i)
            c_OP_AND:  w_sc_res = bus.src1_i & bus.src2_i;
            c_OP_OR:   w_sc_res = bus.src1_i | bus.src2_i;
            c_OP_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
            end
            c_OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            c_OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
            c_OP_SLL:  w_sc_res = bus.src2_i << bus.shamt_i;
            c_OP_SLLV: w_sc_res = bus.src2_i << bus.src1_i[SHW-1:0];
            c_OP_SRL:  w_sc_res = bus.src2_i >> bus.shamt_i;
            c_OP_SRA:  w_sc_res = $unsigned($signed(bus.src2_i) >>> bus.shamt_i);
            c_OP_LUI:  w_sc_res = {bus.src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            c_OP_BNE:  w_sc_res = w_diff;
`ifdef ALU_MULDIV_EN
            // Only taken when the divisor is zero; nonzero divisors go to the engine
            c_OP_DIV, c_OP_DIVU: begin
                w_sc_res = '1;
                w_sc_hi  = bus.src1_i;
                w_sc_dbz = 1'b1;
            end
`endif
            default: ;
        endcase
        w_sc_zero = (w_sc_res == '0);
        if (bus.ctrl_i == c_OP_BNE) begin
            w_sc_zero = (bus.src1_i != bus.src2_i);
        end else if (bus.ctrl_i == c_OP_NOP) begin
            w_sc_zero = 1'b0;
        end
    end

`ifdef ALU_MULDIV_EN
    // One engine step for each mode, plus sign fix-up of the final step
    always_comb begin
        w_signed   = (bus.ctrl_i != c_OP_DIVU);
        w_mag1     = (w_signed && bus.src1_i[WIDTH-1]) ? -bus.src1_i : bus.src1_i;
        w_mag2     = (w_signed && bus.src2_i[WIDTH-1]) ? -bus.src2_i : bus.src2_i;
        w_mul_sum  = {1'b0, eng_q[2*WIDTH-1:WIDTH]} +
                     (eng_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, eng_q[WIDTH-1:1]};
        w_div_tmp  = {eng_q[2*WIDTH-1:WIDTH], eng_q[WIDTH-1]};
        w_div_ge   = (w_div_tmp >= {1'b0, mag_q});
        // Remainder after subtraction is below the divisor, so it fits WIDTH bits
        w_div_rem  = w_div_ge ? (w_div_tmp[WIDTH-1:0] - mag_q) : w_div_tmp[WIDTH-1:0];
        w_div_next = {w_div_rem, eng_q[WIDTH-2:0], w_div_ge};
        w_prod     = neg_lo_q ? -w_mul_next : w_mul_next;
        w_quot     = neg_lo_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
        w_remd     = neg_hi_q ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
        w_last     = (cnt_q == c_LAST);
    end

    assign w_ready = (state_q == S_IDLE) || (state_q == S_DONE);
`else
    assign w_ready = 1'b1;
`endif

    // Next-state and result-register logic
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
`ifdef ALU_MULDIV_EN
        eng_d    = eng_q;
        mag_d    = mag_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
`ifdef ALU_MULDIV_EN
            S_MUL: begin
                eng_d = w_mul_next;
                cnt_d = cnt_q + c_CNT_ONE;
                if (w_last) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = w_prod[WIDTH-1:0];
                    hi_d     = w_prod[2*WIDTH-1:WIDTH];
                    zero_d   = (w_prod[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                end
            end
            S_DIV: begin
                eng_d = w_div_next;
                cnt_d = cnt_q + c_CNT_ONE;
                if (w_last) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = w_quot;
                    hi_d     = w_remd;
                    zero_d   = (w_quot == '0);
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                end
            end
`endif
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (bus.start_i) begin
`ifdef ALU_MULDIV_EN
                    if (bus.ctrl_i == c_OP_MUL) begin
                        state_d  = S_MUL;
                        eng_d    = {{WIDTH{1'b0}}, w_mag2};
                        mag_d    = w_mag1;
                        neg_lo_d = bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1];
                        neg_hi_d = 1'b0;
                        cnt_d    = '0;
                    end else if (((bus.ctrl_i == c_OP_DIV) || (bus.ctrl_i == c_OP_DIVU)) &&
                                 (bus.src2_i != '0)) begin
                        state_d  = S_DIV;
                        eng_d    = {{WIDTH{1'b0}}, w_mag1};
                        mag_d    = w_mag2;
                        neg_lo_d = w_signed && (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
                        neg_hi_d = w_signed && bus.src1_i[WIDTH-1];
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        result_d = w_sc_res;
                        hi_d     = w_sc_hi;
                        zero_d   = w_sc_zero;
                        ovf_d    = w_sc_ovf;
                        dbz_d    = w_sc_dbz;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            eng_q    <= '0;
            mag_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
`ifdef ALU_MULDIV_EN
            eng_q    <= eng_d;
            mag_q    <= mag_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.ready_o       = w_ready;
    assign bus.done_o        = (state_q == S_DONE);
    assign bus.result_o      = result_q;
    assign bus.hi_o          = hi_q;
    assign bus.zero_o        = zero_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule
`default_nettype wire
